// File: rtl/textlcd_arbiter.sv
// 16x2 character LCD sequencer: power-up/init command stream, then round-robin
// arbitration of whole 16-character line writes between two requesters.
module textlcd_arbiter #(
  parameter int PWR_WAIT = 70,
  parameter int E_HIGH   = 4,
  parameter int BYTE_GAP = 20,
  parameter int CLR_WAIT = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic       line0,
  input  logic [7:0] char0,
  input  logic       req1,
  input  logic       line1,
  input  logic [7:0] char1,
  output logic [1:0] gnt,
  output logic [3:0] char_idx,
  output logic       done0,
  output logic       done1,
  output logic       init_done,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  typedef enum logic [2:0] {
    M_PWR  = 3'd0,
    M_INIT = 3'd1,
    M_IDLE = 3'd2,
    M_ADDR = 3'd3,
    M_CHAR = 3'd4,
    M_DONE = 3'd5
  } main_e;

  typedef enum logic [2:0] {
    P_S1   = 3'd0,
    P_S2   = 3'd1,
    P_EH   = 3'd2,
    P_HOLD = 3'd3,
    P_GAP  = 3'd4
  } phase_e;

  localparam logic [15:0] PWR_LAST = 16'(PWR_WAIT - 1);
  localparam logic [15:0] EH_LAST  = 16'(E_HIGH - 1);
  localparam logic [15:0] GAP_LAST = 16'(BYTE_GAP - 1);
  localparam logic [15:0] CLR_LAST = 16'(BYTE_GAP + CLR_WAIT - 1);

  // Function set 8-bit/2-line, display on, entry increment, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h06;
      default: cmd = 8'h01;
    endcase
    return cmd;
  endfunction

  main_e       main_q, main_d;
  phase_e      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last1_q, last1_d;
  logic        line_q, line_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;

  logic [7:0]  slot_byte_s;
  logic        slot_rs_s;
  logic [15:0] gap_last_s;
  logic        win1_s;

  // Byte to send in the current slot, its RS value and the gap length.
  always_comb begin
    slot_byte_s = 8'h00;
    slot_rs_s   = 1'b0;
    gap_last_s  = GAP_LAST;
    case (main_q)
      M_INIT: begin
        slot_byte_s = init_cmd(init_idx_q);
        gap_last_s  = (init_idx_q == 2'd3) ? CLR_LAST : GAP_LAST;
      end
      M_ADDR: slot_byte_s = line_q ? 8'hC0 : 8'h80;
      M_CHAR: begin
        slot_byte_s = gnt_q[1] ? char1 : char0;
        slot_rs_s   = 1'b1;
      end
      default: begin
        slot_byte_s = 8'h00;
        slot_rs_s   = 1'b0;
      end
    endcase
  end

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign win1_s = req1 & (~req0 | ~last1_q);

  // Next-state and registered-output logic for the main FSM and byte slot.
  always_comb begin
    main_d      = main_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    char_idx_d  = char_idx_q;
    gnt_d       = gnt_q;
    last1_d     = last1_q;
    line_d      = line_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    init_done_d = init_done_q;
    data_d      = data_q;
    rs_d        = rs_q;

    case (main_q)
      M_PWR: begin
        if (cnt_q == PWR_LAST) begin
          main_d  = M_INIT;
          phase_d = P_S1;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      M_INIT, M_ADDR, M_CHAR: begin
        case (phase_q)
          P_S1: begin
            data_d  = slot_byte_s;
            rs_d    = slot_rs_s;
            phase_d = P_S2;
          end
          P_S2: begin
            phase_d = P_EH;
            cnt_d   = 16'd0;
          end
          P_EH: begin
            if (cnt_q == EH_LAST) begin
              phase_d = P_HOLD;
              cnt_d   = 16'd0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          P_HOLD: begin
            phase_d = P_GAP;
            cnt_d   = 16'd0;
          end
          P_GAP: begin
            if (cnt_q == gap_last_s) begin
              phase_d = P_S1;
              cnt_d   = 16'd0;
              case (main_q)
                M_INIT: begin
                  if (init_idx_q == 2'd3) begin
                    main_d      = M_IDLE;
                    init_done_d = 1'b1;
                  end else begin
                    init_idx_d = init_idx_q + 2'd1;
                  end
                end
                M_ADDR: begin
                  main_d     = M_CHAR;
                  char_idx_d = 4'd0;
                end
                default: begin
                  if (char_idx_q == 4'd15) begin
                    main_d  = M_DONE;
                    done0_d = gnt_q[0];
                    done1_d = gnt_q[1];
                  end else begin
                    char_idx_d = char_idx_q + 4'd1;
                  end
                end
              endcase
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          default: begin
            phase_d = P_S1;
            cnt_d   = 16'd0;
          end
        endcase
      end

      M_IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win1_s ? 2'b10 : 2'b01;
          line_d  = win1_s ? line1 : line0;
          main_d  = M_ADDR;
          phase_d = P_S1;
          cnt_d   = 16'd0;
        end else begin
          gnt_d = 2'b00;
        end
      end

      M_DONE: begin
        gnt_d   = 2'b00;
        last1_d = gnt_q[1];
        main_d  = M_IDLE;
      end

      default: begin
        main_d  = M_PWR;
        phase_d = P_S1;
        cnt_d   = 16'd0;
      end
    endcase

    e_d    = (phase_d == P_EH);
    busy_d = (main_d != M_IDLE);
  end

  // State and output registers; reset restarts the power-up sequence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q      <= M_PWR;
      phase_q     <= P_S1;
      cnt_q       <= 16'd0;
      init_idx_q  <= 2'd0;
      char_idx_q  <= 4'd0;
      gnt_q       <= 2'b00;
      last1_q     <= 1'b1;
      line_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      main_q      <= main_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      char_idx_q  <= char_idx_d;
      gnt_q       <= gnt_d;
      last1_q     <= last1_d;
      line_q      <= line_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign gnt       = gnt_q;
  assign char_idx  = char_idx_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign LCD_E     = e_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_textlcd_arbiter.sv
// Scoreboard bench for textlcd_arbiter: expected bytes and done pulses are queued
// by the stimulus thread and consumed by a negedge monitor.
module tb_textlcd_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req0, line0, req1, line1;
  logic [7:0] char0, char1;
  logic [1:0] gnt;
  logic [3:0] char_idx;
  logic       done0, done1, init_done, busy;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  always #5 clk = ~clk;

  assign char0 = 8'h41 + {4'h0, char_idx};
  assign char1 = 8'h61 + {4'h0, char_idx};

  textlcd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .line0(line0), .char0(char0),
    .req1(req1), .line1(line1), .char1(char1),
    .gnt(gnt), .char_idx(char_idx), .done0(done0), .done1(done1),
    .init_done(init_done), .busy(busy),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int         dexp_q[$];
  int         rise_q[$];
  int         edge_cnt;

  // Posedges since reset release; at a negedge it names the edge that produced the outputs.
  always @(posedge clk) begin
    if (!resetn) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_line(input int who, input logic ln);
    logic [7:0] base;
    base = (who == 1) ? 8'h61 : 8'h41;
    exp_q.push_back({1'b0, (ln ? 8'hC0 : 8'h80)});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, base + 8'(i)});
    dexp_q.push_back(who);
  endtask

  // Monitor: byte scoreboard, E strobe timing, done pulses and grant release.
  logic       e_prev;
  int         hi_cnt;
  logic [7:0] lat_data, data_prev;
  logic       done_prev;
  logic [8:0] exp_b;
  int         exp_w;
  always @(negedge clk) begin
    if (!resetn) begin
      e_prev    = 1'b0;
      hi_cnt    = 0;
      done_prev = 1'b0;
      data_prev = LCD_DATA;
    end else begin
      if (done_prev) begin
        check("gnt_clear_after_done", gnt, 2'b00);
        check("done_single_cycle", {done1, done0}, 2'b00);
      end
      done_prev = done0 | done1;
      if (done0 | done1) begin
        if (dexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %b expected no done", {done1, done0});
        end else begin
          exp_w = dexp_q.pop_front();
          check("done_id", {done1, done0}, (exp_w == 1) ? 2'b10 : 2'b01);
          check("gnt_at_done", gnt, (exp_w == 1) ? 2'b10 : 2'b01);
        end
      end
      if (LCD_E && !e_prev) begin
        rise_q.push_back(edge_cnt);
        check("rw_low", LCD_RW, 1'b0);
        check("data_setup_stable", LCD_DATA, data_prev);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got rs=%0b data=%0h expected none", LCD_RS, LCD_DATA);
        end else begin
          exp_b = exp_q.pop_front();
          check("lcd_byte", {LCD_RS, LCD_DATA}, exp_b);
        end
        lat_data = LCD_DATA;
        hi_cnt   = 1;
      end else if (LCD_E) begin
        hi_cnt++;
        check("data_stable_e_high", LCD_DATA, lat_data);
      end else if (e_prev) begin
        check("e_high_cycles", hi_cnt, 4);
        check("data_hold_stable", LCD_DATA, lat_data);
      end
      e_prev    = LCD_E;
      data_prev = LCD_DATA;
    end
  end

  task automatic check_reset_outputs();
    check("rst_gnt", gnt, 2'b00);
    check("rst_char_idx", char_idx, 4'd0);
    check("rst_done", {done1, done0}, 2'b00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_lcd_e", LCD_E, 1'b0);
    check("rst_lcd_rs", LCD_RS, 1'b0);
    check("rst_lcd_rw", LCD_RW, 1'b0);
    check("rst_lcd_data", LCD_DATA, 8'h00);
  endtask

  // Wait for init_done; no grant may appear and busy must stay high meanwhile.
  task automatic wait_init();
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (!init_done && n < 600) begin
      @(negedge clk);
      n++;
      if (!init_done && (gnt !== 2'b00 || busy !== 1'b1)) bad = 1'b1;
    end
    check("init_done_reached", init_done, 1'b1);
    check("no_grant_during_init", bad, 1'b0);
    check("init_done_edge", edge_cnt, 278);
    for (int i = 0; i < 4; i++)
      check("init_e_rise_edge", (i < rise_q.size()) ? rise_q[i] : -1, 72 + 27 * i);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int seen, k;
    seen = 0;
    k    = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (done0 | done1) seen++;
    end
    check("done_count", seen, n);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; line0 = 1'b0; line1 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Power-up and init sequence
    rise_q.delete();
    push_init();
    resetn = 1'b1;
    wait_init();
    @(negedge clk);
    check("idle_not_busy", busy, 1'b0);

    // Both requesters held: strict alternation starting with requester 0
    push_line(0, 1'b0); push_line(1, 1'b1); push_line(0, 1'b0); push_line(1, 1'b1);
    line0 = 1'b0; line1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("gnt_both_first", gnt, 2'b01);
    check("busy_in_txn", busy, 1'b1);
    wait_dones(4, 2500);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_alternation", busy, 1'b0);

    // Requester 1 pulsed for a single IDLE cycle still completes
    push_line(1, 1'b0);
    line1 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    check("gnt_pulse_req1", gnt, 2'b10);
    req1 = 1'b0;
    wait_dones(1, 700);
    repeat (2) @(negedge clk);

    // Single requester 0 line write, top line
    push_line(0, 1'b0);
    line0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("gnt_req0_alone", gnt, 2'b01);
    wait_dones(1, 700);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a requester 1 write at char index 7
    push_line(1, 1'b1);
    line1 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("gnt_before_abort", gnt, 2'b10);
    n = 0;
    while (!(char_idx == 4'd7 && LCD_E) && n < 700) begin
      @(negedge clk);
      n++;
    end
    check("reached_idx7", {char_idx, LCD_E}, {4'd7, 1'b1});
    #2 resetn = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    dexp_q.delete();
    req0 = 1'b1; line0 = 1'b0;
    repeat (3) @(negedge clk);
    rise_q.delete();
    push_init();
    push_line(0, 1'b0);
    resetn = 1'b1;
    wait_init();
    @(negedge clk);
    check("gnt_after_reinit_rr_reset", gnt, 2'b01);
    wait_dones(1, 700);
    req0 = 1'b0; req1 = 1'b0;

    repeat (60) @(negedge clk);
    check("final_busy", busy, 1'b0);
    check("final_gnt", gnt, 2'b00);
    check("bytes_outstanding", exp_q.size(), 0);
    check("dones_outstanding", dexp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/textlcd_arbiter.md
Name: textlcd_arbiter

Overview:
Sequences a 16x2 character LCD on the 8-bit parallel bus (LCD_E/RS/RW/DATA) and shares it between two line-writing requesters.
- After reset it runs the power-up and initialisation command sequence.
- It then grants the bus to one requester at a time, with round-robin priority, for whole 16-character line writes.
- LCD_E is a generated strobe with fixed setup/hold timing. It is not the system clock.

Parameters:
PWR_WAIT, 70, idle cycles after reset before the first command
E_HIGH, 4, cycles LCD_E is held high per byte
BYTE_GAP, 20, idle cycles after each byte before the next slot
CLR_WAIT, 100, extra idle cycles after the clear command (0x01)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req0  in  1  requester 0 line-write request; hold high until done0
line0  in  1  requester 0 target line (0=top, 1=bottom)
char0  in  8  requester 0 character for index char_idx (combinational from requester)
req1  in  1  requester 1 request
line1  in  1  requester 1 target line
char1  in  8  requester 1 character for index char_idx
gnt  out  2  one-hot grant, [0]=requester 0
char_idx  out  4  character index 0..15 being fetched
done0  out  1  one-cycle pulse when requester 0 line write completes
done1  out  1  one-cycle pulse when requester 1 line write completes
init_done  out  1  high once the init sequence completes; stays high
busy  out  1  high in every state except IDLE
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  0=command, 1=data
LCD_RW  out  1  always 0 (write only)
LCD_DATA  out  8  LCD data bus

Behaviour:
- Reset (async, resetn=0):
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00.
  - gnt=00, char_idx=0, done0=done1=0, init_done=0, busy=1.
  - Round-robin pointer favours requester 0.
  - Any transaction in progress is abandoned, with no done pulse.
- All outputs are registered.
- Byte slot, used for every byte sent:
  - S1 (1 cycle): char_idx presented; LCD_DATA and LCD_RS registered at the end of S1.
  - S2 (1 cycle): E=0, data stable.
  - EH (E_HIGH cycles): E=1.
  - HOLD (1 cycle): E=0, data stable.
  - GAP (BYTE_GAP cycles; BYTE_GAP+CLR_WAIT for 0x01).
  - Slot length = 3+E_HIGH+BYTE_GAP = 27 cycles at defaults.
  - LCD_DATA/RS only change at the end of S1.
- Main FSM:
  - PWR: count PWR_WAIT cycles, then go to INIT.
  - INIT: send command slots, RS=0, in order 0x38, 0x0C, 0x06, 0x01. After the final GAP, set init_done=1 and go to IDLE.
  - IDLE: busy=0. When any req is high, pick the winner:
    - If only one req is high, it wins.
    - If both are high, the winner is the requester not granted last.
    - Set gnt one-hot on the next cycle, latch the winner's line, go to ADDR.
  - ADDR: one command slot, RS=0, data 0x80 (line 0) or 0xC0 (line 1), then go to CHAR.
  - CHAR: 16 data slots, RS=1, char_idx 0..15.
    - LCD_DATA is taken from the granted requester's char bus at the end of S1.
    - After idx 15's GAP, go to DONE.
  - DONE (1 cycle): pulse done of the granted requester, update the RR pointer to it, clear gnt on the next cycle, return to IDLE.
- Request rules:
  - Requests are ignored before init_done.
  - Deasserting req mid-transaction does not abort; the line completes and done still pulses.
  - A requester holding req high after done is treated as a new request in IDLE, subject to the round-robin pointer.
- char_idx holds its last value outside CHAR; its reset value is 0.

Test Plan:
1. Release reset and count LCD_E rising edges -> first E rise occurs PWR_WAIT+2 cycles after release, with RS=0 and DATA 0x38. Next rises are 0x0C and 0x06, each 27 cycles apart. Then 0x01. init_done rises 127 cycles after the 0x01 slot starts.
2. After init_done, req0=1, line0=0, char0 = 0x41+char_idx -> gnt=01. Bus shows 0x80 (RS=0), then 0x41..0x50 (RS=1). done0 pulses once. gnt returns to 00 one cycle after done0.
3. req0 and req1 asserted in the same IDLE cycle and held -> requester 0 is served first. Then requester 1 (line1=1, first byte 0xC0). Then requester 0 again, strictly alternating.
4. Timing check on every byte -> E high exactly E_HIGH=4 cycles. LCD_DATA is stable from 1 cycle before E rises until 1 cycle after E falls. LCD_RW is 0 throughout.
5. resetn pulsed low during CHAR at idx 7 -> outputs at reset values immediately, with no done pulse. Full init sequence repeats before any new grant.
6. req1 pulsed for one cycle in IDLE, then dropped -> full 17-byte transaction completes and done1 pulses.
